axi_stream_extract_header: RTL

// - Receive-side counterpart of the header inserter: strips a 1..DATA_BYTE_WD-byte header

---
 rtl/axis_hdr_pkg.sv | 34 +++
 rtl/axi_stream_extract_header_realigner.sv | 42 ++++
 rtl/skidbuffer.sv | 45 ++++
 rtl/axi_stream_extract_header.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared types and keep/count helpers for the AXI Stream header extractor.
package axis_hdr_pkg;

  localparam int unsigned MAX_BYTES = 64;

  typedef logic [7:0]           byte_cnt_t;
  typedef logic [MAX_BYTES-1:0] keep_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic byte_cnt_t keep2cnt(keep_t keep);
    byte_cnt_t cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      cnt = cnt + byte_cnt_t'(keep[i]);
    end
    return cnt;
  endfunction

  function automatic keep_t cnt2keep_lsb(byte_cnt_t cnt);
    if (cnt >= byte_cnt_t'(MAX_BYTES)) return '1;
    return (keep_t'(1) << cnt) - keep_t'(1);
  endfunction

  // MSB-contiguous mask of cnt ones inside an nbytes-wide keep
  function automatic keep_t cnt2keep_msb(byte_cnt_t cnt, byte_cnt_t nbytes);
    return cnt2keep_lsb(cnt) << (nbytes - cnt);
  endfunction

endpackage

// File: rtl/axi_stream_extract_header_realigner.sv
// Merges the left-aligned residue with the next beat and splits the result into
// one output beat plus the bytes that spill into the next residue.
module byte_realigner
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic [DATA_WD-1:0]      res_data_i,
  input  byte_cnt_t               res_cnt_i,
  input  logic [DATA_WD-1:0]      beat_data_i,
  input  logic [DATA_BYTE_WD-1:0] beat_keep_i,
  output logic [DATA_WD-1:0]      out_data_o,
  output logic [DATA_BYTE_WD-1:0] out_keep_o,
  output logic [DATA_WD-1:0]      res_data_o,
  output byte_cnt_t               res_cnt_o,
  output logic                    overflow_o
);

  localparam byte_cnt_t NB = byte_cnt_t'(DATA_BYTE_WD);

  logic [DATA_WD-1:0]   beat_mask;
  logic [2*DATA_WD-1:0] merged;
  byte_cnt_t            total;

  always_comb begin
    beat_mask = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      beat_mask[i*8 +: 8] = {8{beat_keep_i[i]}};
    end
    total  = res_cnt_i + keep2cnt(keep_t'(beat_keep_i));
    // invalid tail bytes are cleared so they never pollute a later residue
    merged = {res_data_i, {DATA_WD{1'b0}}}
           | ({beat_data_i & beat_mask, {DATA_WD{1'b0}}} >> {res_cnt_i, 3'b000});
    overflow_o = total > NB;
    out_data_o = merged[2*DATA_WD-1 -: DATA_WD];
    res_data_o = merged[DATA_WD-1:0];
    res_cnt_o  = overflow_o ? total - NB : '0;
    out_keep_o = (total >= NB) ? '1 : DATA_BYTE_WD'(cnt2keep_msb(total, NB));
  end

endmodule

// File: rtl/skidbuffer.sv
// Two-entry skid buffer: registered output, ready_o driven only from a register.
module skidbuffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_vld_q;
  logic             skid_vld_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_ready_i || !out_vld_q) begin
      out_vld_q  <= skid_vld_q || in_valid_i;
      skid_vld_q <= 1'b0;
    end else if (in_valid_i && !skid_vld_q) begin
      skid_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (out_ready_i || !out_vld_q) begin
      out_q <= skid_vld_q ? skid_q : in_data_i;
    end
    if (in_valid_i && !skid_vld_q && out_vld_q && !out_ready_i) begin
      skid_q <= in_data_i;
    end
  end

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a per-packet 1..DATA_BYTE_WD byte header from an AXI Stream and forwards
// the realigned payload; header and payload leave through independent skid buffers.
module axi_stream_extract_header
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    valid_cfg,
  output logic                    ready_cfg,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header
);

  localparam byte_cnt_t NB    = byte_cnt_t'(DATA_BYTE_WD);
  localparam int        PL_WD = DATA_WD + DATA_BYTE_WD + 1;
  localparam int        HD_WD = DATA_WD + DATA_BYTE_WD;

  state_t             state_q, state_d;
  logic [DATA_WD-1:0] res_q, res_d;
  byte_cnt_t          res_cnt_q, res_cnt_d;

  byte_cnt_t v_in, h_in, hmin;
  logic      pl_rdy, hd_rdy, pl_push, hd_push, pl_vld, hd_vld;
  logic [DATA_WD-1:0]      pl_data, hd_data;
  logic [DATA_BYTE_WD-1:0] pl_keep, hd_keep;
  logic                    pl_last;

  logic [DATA_WD-1:0]      ra_data, ra_res;
  logic [DATA_BYTE_WD-1:0] ra_keep;
  byte_cnt_t               ra_res_cnt;
  logic                    ra_ovf;

  assign v_in = keep2cnt(keep_t'(keep_in));
  assign h_in = byte_cnt_t'(byte_strip_cnt) + 8'd1;
  assign hmin = (v_in < h_in) ? v_in : h_in;

  // config and first beat are only ever consumed together
  assign ready_in  = rst_n && pl_rdy &&
                     (((state_q == IDLE) && valid_cfg && hd_rdy) || (state_q == BODY));
  assign ready_cfg = rst_n && (state_q == IDLE) && pl_rdy && hd_rdy && valid_in;

  byte_realigner #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD)
  ) u_realigner (
    .res_data_i  (res_q),
    .res_cnt_i   (res_cnt_q),
    .beat_data_i (data_in),
    .beat_keep_i (keep_in),
    .out_data_o  (ra_data),
    .out_keep_o  (ra_keep),
    .res_data_o  (ra_res),
    .res_cnt_o   (ra_res_cnt),
    .overflow_o  (ra_ovf)
  );

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    res_cnt_d = res_cnt_q;
    hd_push   = 1'b0;
    pl_push   = 1'b0;
    hd_data   = data_in >> {NB - hmin, 3'b000};
    hd_keep   = DATA_BYTE_WD'(cnt2keep_lsb(hmin));
    pl_data   = ra_data;
    pl_keep   = ra_keep;
    pl_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_in) begin
          hd_push   = 1'b1;
          res_d     = data_in << {h_in, 3'b000};
          res_cnt_d = (v_in > h_in) ? v_in - h_in : '0;
          if (!last_in)         state_d = BODY;
          else if (v_in > h_in) state_d = FLUSH;
        end
      end
      BODY: begin
        if (valid_in && ready_in) begin
          pl_push   = 1'b1;
          res_d     = ra_res;
          res_cnt_d = ra_res_cnt;
          if (last_in) begin
            pl_last = !ra_ovf;
            state_d = ra_ovf ? FLUSH : IDLE;
          end
        end
      end
      FLUSH: begin
        if (pl_rdy) begin
          pl_push   = 1'b1;
          pl_data   = res_q;
          pl_keep   = DATA_BYTE_WD'(cnt2keep_msb(res_cnt_q, NB));
          pl_last   = 1'b1;
          res_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      res_q     <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  skidbuffer #(.WIDTH(PL_WD)) u_pl_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (pl_push),
    .in_ready_o  (pl_rdy),
    .in_data_i   ({pl_data, pl_keep, pl_last}),
    .out_valid_o (pl_vld),
    .out_ready_i (ready_out),
    .out_data_o  ({data_out, keep_out, last_out})
  );

  skidbuffer #(.WIDTH(HD_WD)) u_hd_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (hd_push),
    .in_ready_o  (hd_rdy),
    .in_data_i   ({hd_data, hd_keep}),
    .out_valid_o (hd_vld),
    .out_ready_i (ready_header),
    .out_data_o  ({data_header, keep_header})
  );

  assign valid_out    = pl_vld && rst_n;
  assign valid_header = hd_vld && rst_n;

endmodule
